// File: rtl/pb_cmd_pkg.sv
// Shared types and constants for the pushbutton command decoder.
package pb_cmd_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PRESS_DB,
        HOLD,
        REPEAT,
        RELEASE_DB
    } pb_state_t;

    localparam int DEF_N_BUTTONS       = 5;
    localparam int DEF_DEBOUNCE_CYCLES = 3;
    localparam int DEF_REPEAT_DELAY    = 50;
    localparam int DEF_REPEAT_RATE     = 10;

    // Bits needed to hold counts 0 .. max(a,b,c)-1. The counter never goes
    // past a terminal value, so it never needs to saturate.
    function automatic int cnt_width(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return (m < 2) ? 1 : $clog2(m);
    endfunction

    // Bits needed to index n buttons.
    function automatic int idx_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/pb_sync.sv
// Two-flop synchroniser for the raw pushbutton levels.
module pb_sync #(
    parameter int WIDTH = 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] stage1_reg;
    logic [WIDTH-1:0] stage2_reg;

    // Both stages clear on reset so a held button re-enters as a fresh press.
    always_ff @(posedge clock) begin
        if (reset) begin
            stage1_reg <= '0;
            stage2_reg <= '0;
        end else begin
            stage1_reg <= d;
            stage2_reg <= stage1_reg;
        end
    end

    assign q = stage2_reg;

endmodule

// File: rtl/pb_command_decoder.sv
// Pushbutton front end: synchronise, debounce, arbitrate to one owner,
// and emit single-cycle increment pulses with optional hold-to-repeat.
module pb_command_decoder
    import pb_cmd_pkg::*;
#(
    parameter int N_BUTTONS       = DEF_N_BUTTONS,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int REPEAT_RATE     = DEF_REPEAT_RATE
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [N_BUTTONS-1:0] pb_raw,
    input  logic [N_BUTTONS-1:0] repeat_en,
    output logic [N_BUTTONS-1:0] inc_pulse,
    output logic [N_BUTTONS-1:0] held,
    output logic                 busy
);

    localparam int CNT_W = cnt_width(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_RATE);
    localparam int OWN_W = idx_width(N_BUTTONS);

    logic [N_BUTTONS-1:0] pb_s;

    pb_cmd_pkg::pb_state_t state_reg, state_next;
    logic [CNT_W-1:0]     cnt_reg, cnt_next;
    logic [OWN_W-1:0]     owner_reg, owner_next;
    logic                 pulse_next;
    logic [N_BUTTONS-1:0] inc_pulse_reg, held_reg;
    logic [N_BUTTONS-1:0] owner_onehot;
    logic [OWN_W-1:0]     lowest_idx;
    logic [CNT_W-1:0]     hold_term;

    pb_sync #(.WIDTH(N_BUTTONS)) u_sync (
        .clock (clock),
        .reset (reset),
        .d     (pb_raw),
        .q     (pb_s)
    );

    // Lowest-index pressed button wins arbitration.
    always_comb begin
        lowest_idx = '0;
        for (int i = N_BUTTONS - 1; i >= 0; i--) begin
            if (pb_s[i]) lowest_idx = OWN_W'(i);
        end
    end

    // Outputs are decoded from the owner the FSM will hold after this edge.
    generate
        for (genvar gi = 0; gi < N_BUTTONS; gi++) begin : g_onehot
            assign owner_onehot[gi] = (owner_next == OWN_W'(gi));
        end
    endgenerate

    // HOLD waits the long initial delay, REPEAT the shorter repeat period.
    assign hold_term = (state_reg == HOLD) ? CNT_W'(REPEAT_DELAY - 1)
                                           : CNT_W'(REPEAT_RATE - 1);

    // Next-state, counter and pulse decision.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        owner_next = owner_reg;
        pulse_next = 1'b0;
        case (state_reg)
            IDLE: begin
                if (|pb_s) begin
                    owner_next = lowest_idx;
                    cnt_next   = '0;
                    state_next = PRESS_DB;
                end
            end
            PRESS_DB: begin
                if (!pb_s[owner_reg]) begin
                    state_next = IDLE;
                end else if (cnt_reg == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                    pulse_next = 1'b1;
                    cnt_next   = '0;
                    state_next = HOLD;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            HOLD, REPEAT: begin
                if (!pb_s[owner_reg]) begin
                    cnt_next   = '0;
                    state_next = RELEASE_DB;
                end else if (!repeat_en[owner_reg]) begin
                    cnt_next = cnt_reg;
                end else if (cnt_reg == hold_term) begin
                    pulse_next = 1'b1;
                    cnt_next   = '0;
                    state_next = REPEAT;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            RELEASE_DB: begin
                // Any button, owner or not, restarts the release window.
                if (|pb_s) begin
                    cnt_next = '0;
                end else if (cnt_reg == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                    state_next = IDLE;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
                owner_next = '0;
            end
        endcase
    end

    // State, counter, owner and registered outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg     <= IDLE;
            cnt_reg       <= '0;
            owner_reg     <= '0;
            inc_pulse_reg <= '0;
            held_reg      <= '0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            owner_reg     <= owner_next;
            inc_pulse_reg <= pulse_next ? owner_onehot : '0;
            held_reg      <= ((state_next == HOLD) || (state_next == REPEAT))
                             ? owner_onehot : '0;
        end
    end

    assign inc_pulse = inc_pulse_reg;
    assign held      = held_reg;
    assign busy      = (state_reg != IDLE);

endmodule

// File: tb/tb_pb_command_decoder.sv
// Directed bench for pb_command_decoder; expected values are hand-derived
// edge by edge, with edge 0 the first edge that samples the new pb_raw level.
module tb_pb_command_decoder;

    logic       clock;
    logic       reset;
    logic [4:0] pb_raw;
    logic [4:0] repeat_en;
    logic [4:0] inc_pulse;
    logic [4:0] held;
    logic       busy;

    int checks;
    int errors;

    pb_command_decoder #(
        .N_BUTTONS       (5),
        .DEBOUNCE_CYCLES (3),
        .REPEAT_DELAY    (50),
        .REPEAT_RATE     (10)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .pb_raw    (pb_raw),
        .repeat_en (repeat_en),
        .inc_pulse (inc_pulse),
        .held      (held),
        .busy      (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive inputs, take one edge, then settle 1 time unit past it.
    task automatic tick(input logic [4:0] raw, input logic rst);
        pb_raw = raw;
        reset  = rst;
        @(posedge clock);
        #1;
    endtask

    function automatic bit in_rng(input int k, input int lo, input int hi);
        return (k >= lo) && (k <= hi);
    endfunction

    function automatic int case_len(input int id);
        case (id)
            1: return 30;
            2: return 15;
            4: return 110;
            default: return 210;
        endcase
    endfunction

    function automatic logic [4:0] case_en(input int id);
        return (id == 5 || id == 6) ? 5'b01111 : 5'b11111;
    endfunction

    function automatic logic [4:0] raw_of(input int id, input int k);
        case (id)
            1: return (k < 20) ? 5'b00001 : 5'b00000;
            2: return (k == 0 || k == 1 || k == 3 || k == 4) ? 5'b00010 : 5'b00000;
            3: return (k < 200) ? 5'b00100 : 5'b00000;
            4: return ((k < 40) ? 5'b00010 : 5'b00000) | ((k < 100) ? 5'b01000 : 5'b00000);
            default: return (k < 200) ? 5'b10000 : 5'b00000;
        endcase
    endfunction

    function automatic logic rst_of(input int id, input int k);
        return (id == 6) && (k == 30);
    endfunction

    function automatic logic [4:0] exp_inc(input int id, input int k);
        case (id)
            1: return (k == 5) ? 5'b00001 : 5'b00000;
            2: return 5'b00000;
            3: return (k == 5 || (in_rng(k, 55, 195) && ((k - 55) % 10 == 0))) ? 5'b00100 : 5'b00000;
            4: return (k == 5) ? 5'b00010 : 5'b00000;
            5: return (k == 5) ? 5'b10000 : 5'b00000;
            default: return (k == 5 || k == 36) ? 5'b10000 : 5'b00000;
        endcase
    endfunction

    function automatic logic [4:0] exp_held(input int id, input int k);
        case (id)
            1: return in_rng(k, 5, 21) ? 5'b00001 : 5'b00000;
            2: return 5'b00000;
            3: return in_rng(k, 5, 201) ? 5'b00100 : 5'b00000;
            4: return in_rng(k, 5, 41) ? 5'b00010 : 5'b00000;
            5: return in_rng(k, 5, 201) ? 5'b10000 : 5'b00000;
            default: return (in_rng(k, 5, 29) || in_rng(k, 36, 201)) ? 5'b10000 : 5'b00000;
        endcase
    endfunction

    function automatic logic exp_busy(input int id, input int k);
        case (id)
            1: return in_rng(k, 2, 24);
            2: return in_rng(k, 2, 3) || in_rng(k, 5, 6);
            3: return in_rng(k, 2, 204);
            4: return in_rng(k, 2, 103);
            5: return in_rng(k, 2, 204);
            default: return in_rng(k, 2, 29) || in_rng(k, 33, 204);
        endcase
    endfunction

    function automatic int exp_count(input int id);
        case (id)
            2: return 0;
            3: return 16;
            6: return 2;
            default: return 1;
        endcase
    endfunction

    task automatic run_case(input int id);
        int pulses;
        pulses    = 0;
        repeat_en = case_en(id);
        for (int k = 0; k < case_len(id); k++) begin
            tick(raw_of(id, k), rst_of(id, k));
            if (inc_pulse != 5'b00000) pulses++;
            check_val($sformatf("c%0d_inc_k%0d", id, k), 32'(inc_pulse), 32'(exp_inc(id, k)));
            check_val($sformatf("c%0d_held_k%0d", id, k), 32'(held), 32'(exp_held(id, k)));
            check_val($sformatf("c%0d_busy_k%0d", id, k), 32'(busy), 32'(exp_busy(id, k)));
        end
        check_val($sformatf("c%0d_pulse_count", id), 32'(pulses), 32'(exp_count(id)));
        $display("case %0d: %0d edges, %0d pulses seen", id, case_len(id), pulses);
        // Quiet gap so the next case starts from IDLE with pb_s cleared.
        for (int k = 0; k < 5; k++) tick(5'b00000, 1'b0);
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        pb_raw    = 5'b00000;
        repeat_en = 5'b11111;
        reset     = 1'b1;

        for (int k = 0; k < 3; k++) begin
            tick(5'b00000, 1'b1);
            check_val($sformatf("rst_inc_%0d", k), 32'(inc_pulse), 32'd0);
            check_val($sformatf("rst_held_%0d", k), 32'(held), 32'd0);
            check_val($sformatf("rst_busy_%0d", k), 32'(busy), 32'd0);
        end
        $display("reset: 3 edges applied");
        for (int k = 0; k < 3; k++) tick(5'b00000, 1'b0);

        for (int id = 1; id <= 6; id++) run_case(id);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
